// File: rtl/hbridge_pwm_pkg.sv
// Shared motor-control definitions: PWM state encoding, default timing
// constants and the bridge direction encodings.
package hbridge_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DEAD  = 2'd2
    } pwm_state_e;

    localparam int unsigned PWM_PERIOD_DEFAULT   = 800;
    localparam int unsigned PWM_DEADTIME_DEFAULT = 16;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/hbridge_pwm.sv
// Signed duty word to complementary-direction PWM for one H-bridge channel,
// with duty latched at period boundaries and dead time on every reversal.
module hbridge_pwm
    import hbridge_pwm_pkg::*;
#(
    parameter int unsigned PERIOD   = PWM_PERIOD_DEFAULT,
    parameter int unsigned DEADTIME = PWM_DEADTIME_DEFAULT,
    parameter int unsigned DUTY_W   = 24
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic signed [DUTY_W-1:0] duty,
    input  logic                     enable,
    output logic                     pwm_a,
    output logic                     pwm_b,
    output logic                     dir,
    output logic                     period_start
);

    localparam int unsigned        CNT_W         = $clog2(PERIOD);
    localparam int unsigned        MAG_W         = $clog2(PERIOD + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST      = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]   DEAD_LOAD     = CNT_W'((DEADTIME == 0) ? 0 : DEADTIME - 1);
    localparam logic [MAG_W-1:0]   MAG_FULL      = MAG_W'(PERIOD);
    localparam logic [DUTY_W:0]    MAG_FULL_WIDE = (DUTY_W + 1)'(PERIOD);

    // One extra bit keeps |-2^(DUTY_W-1)| representable before saturation.
    function automatic logic [MAG_W-1:0] sat_mag(input logic signed [DUTY_W-1:0] d);
        logic [DUTY_W:0] abs_v;
        if (d[DUTY_W-1]) abs_v = {1'b0, ~d} + (DUTY_W + 1)'(1);
        else             abs_v = {1'b0, d};
        sat_mag = (abs_v > MAG_FULL_WIDE) ? MAG_FULL : MAG_W'(abs_v);
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic [MAG_W-1:0] r_mag;
    logic             r_sign;
    pwm_state_e       r_state;
    logic             r_dir;
    logic [CNT_W-1:0] r_dead;
    logic             r_pwm_a;
    logic             r_pwm_b;
    logic             r_period_start;

    logic             w_boundary;
    logic [MAG_W-1:0] w_mag;
    logic             w_sign;
    pwm_state_e       w_state_nxt;
    logic             w_dir_nxt;
    logic [CNT_W-1:0] w_dead_nxt;
    logic             w_drive;
    logic             w_drive_dir;
    logic             w_reverse;
    logic             w_on;

    // At the boundary the freshly latched duty is used directly so the
    // compare for cnt == 0 already reflects the new period's magnitude.
    assign w_boundary = (r_cnt == '0);
    assign w_mag      = w_boundary ? sat_mag(duty) : r_mag;
    assign w_sign     = w_boundary ? duty[DUTY_W-1] : r_sign;

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_dead_nxt  = r_dead;
        w_drive     = 1'b0;
        w_drive_dir = r_dir;
        w_reverse   = 1'b0;
        w_on        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_boundary && (w_mag != '0)) begin
                    if (w_sign == r_dir) begin
                        w_state_nxt = DRIVE;
                        w_drive     = 1'b1;
                    end else begin
                        w_reverse = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (w_boundary && (w_mag != '0) && (w_sign != r_dir)) w_reverse = 1'b1;
                else                                                   w_drive   = 1'b1;
            end
            DEAD: begin
                if (r_dead == '0) begin
                    w_state_nxt = DRIVE;
                    w_dir_nxt   = r_sign;
                    w_drive_dir = r_sign;
                    w_drive     = 1'b1;
                end else begin
                    w_dead_nxt = r_dead - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_reverse) begin
            if (DEADTIME == 0) begin
                w_state_nxt = DRIVE;
                w_dir_nxt   = w_sign;
                w_drive_dir = w_sign;
                w_drive     = 1'b1;
            end else begin
                w_state_nxt = DEAD;
                w_dead_nxt  = DEAD_LOAD;
            end
        end

        if (!enable) begin
            w_state_nxt = IDLE;
            w_dir_nxt   = r_dir;
            w_drive     = 1'b0;
        end

        w_on = w_drive && (MAG_W'(r_cnt) < w_mag);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_cnt          <= '0;
            r_mag          <= '0;
            r_sign         <= 1'b0;
            r_state        <= IDLE;
            r_dir          <= DIR_POS;
            r_dead         <= '0;
            r_pwm_a        <= 1'b0;
            r_pwm_b        <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            r_period_start <= w_boundary;
            if (w_boundary) begin
                r_mag  <= w_mag;
                r_sign <= w_sign;
            end
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_dead  <= w_dead_nxt;
            r_pwm_a <= w_on && (w_drive_dir == DIR_POS);
            r_pwm_b <= w_on && (w_drive_dir == DIR_NEG);
        end
    end

    assign pwm_a        = r_pwm_a;
    assign pwm_b        = r_pwm_b;
    assign dir          = r_dir;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_hbridge_pwm.sv
// Directed bench for hbridge_pwm: per-period pulse statistics against
// hand-computed values, then random duty/enable with reset pulses.
module tb_hbridge_pwm;

    localparam int PER = 800;
    localparam int DW  = 24;

    typedef struct {
        int   na, fa, la;
        int   nb, fb, lb;
        int   nov, nps;
        logic dmid, dend;
    } meas_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic signed [DW-1:0] duty;
    logic                 pwm_a;
    logic                 pwm_b;
    logic                 dir;
    logic                 period_start;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hbridge_pwm #(
        .PERIOD   (PER),
        .DEADTIME (16),
        .DUTY_W   (DW)
    ) dut (
        .CLK          (clk),
        .reset        (reset),
        .duty         (duty),
        .enable       (enable),
        .pwm_a        (pwm_a),
        .pwm_b        (pwm_b),
        .dir          (dir),
        .period_start (period_start)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Returns at the negedge of the cycle where period_start is high.
    task automatic wait_ps(input string tag, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (period_start !== 1'b1 && waited < 2 * PER);
        check({tag, ".ps_seen"}, int'(period_start === 1'b1), 1);
    endtask

    // Window index i shows the registered result of the compare at cnt == i.
    task automatic measure(input int i1, input logic signed [DW-1:0] d1, input logic e1,
                           input int i2, input logic signed [DW-1:0] d2, input logic e2,
                           output meas_t m);
        m.na = 0; m.fa = -1; m.la = -1;
        m.nb = 0; m.fb = -1; m.lb = -1;
        m.nov = 0; m.nps = 0; m.dmid = 1'b0; m.dend = 1'b0;
        for (int i = 0; i < PER; i++) begin
            if (i > 0) @(negedge clk);
            if (pwm_a === 1'b1) begin m.na++; if (m.fa < 0) m.fa = i; m.la = i; end
            if (pwm_b === 1'b1) begin m.nb++; if (m.fb < 0) m.fb = i; m.lb = i; end
            if (pwm_a === 1'b1 && pwm_b === 1'b1) m.nov++;
            if (period_start === 1'b1) m.nps++;
            if (i == 8) m.dmid = dir;
            if (i == PER - 1) m.dend = dir;
            if (i == i1) begin duty = d1; enable = e1; end
            if (i == i2) begin duty = d2; enable = e2; end
        end
    endtask

    task automatic run_period(input string tag,
                              input int i1, input logic signed [DW-1:0] d1, input logic e1,
                              input int i2, input logic signed [DW-1:0] d2, input logic e2,
                              input int ena, input int efa, input int ela,
                              input int enb, input int efb, input int elb,
                              input int edir, input int emid);
        int    w;
        meas_t m;
        wait_ps(tag, w);
        check({tag, ".gap"}, w, 1);
        measure(i1, d1, e1, i2, d2, e2, m);
        check({tag, ".na"}, m.na, ena);
        check({tag, ".fa"}, m.fa, efa);
        check({tag, ".la"}, m.la, ela);
        check({tag, ".nb"}, m.nb, enb);
        check({tag, ".fb"}, m.fb, efb);
        check({tag, ".lb"}, m.lb, elb);
        check({tag, ".overlap"}, m.nov, 0);
        check({tag, ".nps"}, m.nps, 1);
        check({tag, ".dir_end"}, int'(m.dend), edir);
        if (emid >= 0) check({tag, ".dir_mid"}, int'(m.dmid), emid);
    endtask

    initial begin
        int w;
        reset  = 1'b1;
        enable = 1'b1;
        duty   = 24'sd200;
        repeat (3) @(negedge clk);
        check("rst.pwm_a", int'(pwm_a), 0);
        check("rst.pwm_b", int'(pwm_b), 0);
        check("rst.dir", int'(dir), 0);
        check("rst.period_start", int'(period_start), 0);
        reset = 1'b0;

        run_period("p200", -1, '0, 1'b1, -1, '0, 1'b1, 200, 0, 199, 0, -1, -1, 0, -1);
        duty = '0;
        run_period("zero1", -1, '0, 1'b1, -1, '0, 1'b1, 0, -1, -1, 0, -1, -1, 0, -1);
        duty = 24'sd100;
        run_period("p100", -1, '0, 1'b1, -1, '0, 1'b1, 100, 0, 99, 0, -1, -1, 0, -1);
        duty = '0;
        run_period("zero2", -1, '0, 1'b1, -1, '0, 1'b1, 0, -1, -1, 0, -1, -1, 0, -1);
        duty = 24'sd200;
        run_period("en_drop", 49, 24'sd200, 1'b0, 299, 24'sd200, 1'b1,
                   50, 0, 49, 0, -1, -1, 0, -1);
        run_period("en_resume", -1, '0, 1'b1, -1, '0, 1'b1, 200, 0, 199, 0, -1, -1, 0, -1);
        duty = 24'sd2000;
        run_period("full1", -1, '0, 1'b1, -1, '0, 1'b1, 800, 0, 799, 0, -1, -1, 0, -1);
        run_period("full2", -1, '0, 1'b1, -1, '0, 1'b1, 800, 0, 799, 0, -1, -1, 0, -1);
        duty = 24'h800000;
        run_period("rev_neg", -1, '0, 1'b1, -1, '0, 1'b1, 0, -1, -1, 784, 16, 799, 1, 0);
        run_period("full_neg", -1, '0, 1'b1, -1, '0, 1'b1, 0, -1, -1, 800, 0, 799, 1, -1);
        duty = 24'sd300;
        run_period("rev_pos", -1, '0, 1'b1, -1, '0, 1'b1, 284, 16, 299, 0, -1, -1, 0, 1);
        run_period("p300", -1, '0, 1'b1, -1, '0, 1'b1, 300, 0, 299, 0, -1, -1, 0, -1);
        run_period("mid_change", 399, -24'sd300, 1'b1, -1, '0, 1'b1,
                   300, 0, 299, 0, -1, -1, 0, -1);
        run_period("rev_300", -1, '0, 1'b1, -1, '0, 1'b1, 0, -1, -1, 284, 16, 299, 1, 0);

        for (int it = 0; it < 6; it++) begin
            int ncy;
            int nov;
            ncy = $urandom_range(800, 2400);
            nov = 0;
            for (int c = 0; c < ncy; c++) begin
                @(negedge clk);
                if (pwm_a === 1'b1 && pwm_b === 1'b1) nov++;
                if ($urandom_range(0, 47) == 0) duty = DW'(int'($urandom_range(0, 2000)) - 1000);
                if ($urandom_range(0, 299) == 0) enable = ~enable;
            end
            check($sformatf("rand%0d.overlap", it), nov, 0);
            #2 reset = 1'b1;
            #1;
            check($sformatf("rand%0d.rst_pwm", it), int'(pwm_a | pwm_b), 0);
            check($sformatf("rand%0d.rst_ps", it), int'(period_start), 0);
            check($sformatf("rand%0d.rst_dir", it), int'(dir), 0);
            @(negedge clk);
            @(negedge clk);
            reset  = 1'b0;
            enable = 1'b1;
            wait_ps($sformatf("rand%0d.release", it), w);
            check($sformatf("rand%0d.release_lat", it), w, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
